// File: rtl/dispatch_queue.sv
// Circular instruction queue between fetch and decode: accepts up to FETCH_W
// lanes per cycle, dispatches one per cycle, and stops fetching once an HLT is queued.
module dispatch_queue #(
   parameter int DEPTH   = 8,
   parameter int FETCH_W = 2,
   parameter int INSN_W  = 32,
   parameter int PC_W    = 64
) (
   input  logic                         in_clk,
   input  logic                         in_rst_n,
   input  logic                         in_flush,
   input  logic [FETCH_W-1:0]           in_fetch_valid,
   input  logic [FETCH_W*INSN_W-1:0]    in_fetch_insnbits,
   input  logic [FETCH_W*PC_W-1:0]      in_fetch_pc,
   output logic                         out_fetch_ready,
   output logic                         out_disp_valid,
   output logic [INSN_W-1:0]            out_disp_insnbits,
   output logic [PC_W-1:0]              out_disp_pc,
   input  logic                         in_disp_ready,
   output logic [$clog2(DEPTH+1)-1:0]   out_count,
   output logic                         out_halted
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [INSN_W-1:0] mem_insn [DEPTH];
   logic [PC_W-1:0]   mem_pc   [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             halted_q, halted_d;

   logic [INSN_W-1:0] lane_insn [FETCH_W];
   logic [PC_W-1:0]   lane_pc   [FETCH_W];
   logic [FETCH_W-1:0] lane_hlt;
   logic [FETCH_W-1:0] lane_acc;
   logic [CNT_W-1:0]   acc_cnt;
   logic               acc_hlt;
   logic               keep;
   logic [CNT_W-1:0]   free_slots;
   logic               deq;

   genvar gi;
   generate
      for (gi = 0; gi < FETCH_W; gi++) begin : g_lane
         assign lane_insn[gi] = in_fetch_insnbits[gi*INSN_W +: INSN_W];
         assign lane_pc[gi]   = in_fetch_pc[gi*PC_W +: PC_W];
         // HLT #imm: fixed opcode bits [31:21], imm16 in [20:5] is ignored
         assign lane_hlt[gi]  = (lane_insn[gi][31:21] == 11'b110_1010_0010) &&
                                (lane_insn[gi][4:0] == 5'b0_0000);
      end
   endgenerate

   // No credit is taken for a same-cycle dequeue.
   assign free_slots      = CNT_W'(DEPTH) - count_q;
   assign out_fetch_ready = (free_slots >= CNT_W'(FETCH_W)) & ~halted_q & ~in_flush;

   // Accept the contiguous valid prefix, closing the group after an HLT lane.
   always_comb begin
      lane_acc = '0;
      acc_cnt  = '0;
      acc_hlt  = 1'b0;
      keep     = out_fetch_ready;
      for (int i = 0; i < FETCH_W; i++) begin
         if (keep && in_fetch_valid[i]) begin
            lane_acc[i] = 1'b1;
            acc_cnt     = acc_cnt + CNT_W'(1);
            if (lane_hlt[i]) begin
               acc_hlt = 1'b1;
               keep    = 1'b0;
            end
         end else begin
            keep = 1'b0;
         end
      end
   end

   assign out_disp_valid    = (count_q != '0);
   assign out_disp_insnbits = mem_insn[head_q];
   assign out_disp_pc       = mem_pc[head_q];
   assign out_count         = count_q;
   assign out_halted        = halted_q;

   assign deq = out_disp_valid & in_disp_ready;

   always_comb begin
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      halted_d = halted_q;
      if (in_flush) begin
         head_d   = '0;
         tail_d   = '0;
         count_d  = '0;
         halted_d = 1'b0;
      end else begin
         tail_d  = tail_q + PTR_W'(acc_cnt);
         head_d  = head_q + PTR_W'(deq);
         count_d = count_q + acc_cnt - CNT_W'(deq);
         if (acc_hlt) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         halted_q <= halted_d;
      end
   end

   // Storage is not reset; occupancy is defined by the pointers alone.
   always_ff @(posedge in_clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (lane_acc[i]) begin
            mem_insn[tail_q + PTR_W'(i)] <= lane_insn[i];
            mem_pc[tail_q + PTR_W'(i)]   <= lane_pc[i];
         end
      end
   end

`ifdef DEBUG
`ifndef SYNTHESIS
   always @(posedge in_clk) begin
      if (in_rst_n) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (lane_acc[i]) begin
               $display("[dispatch_queue] enq pc=%h insn=%h", lane_pc[i], lane_insn[i]);
            end
         end
         if (deq && !in_flush) begin
            $display("[dispatch_queue] deq pc=%h insn=%h", out_disp_pc, out_disp_insnbits);
         end
      end
   end
`endif
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue at DEPTH=8, FETCH_W=2: fill, order, lane
// masking, HLT, pointer wrap, flush and asynchronous reset.
module tb_dispatch_queue;

   localparam int DEPTH   = 8;
   localparam int FETCH_W = 2;
   localparam int INSN_W  = 32;
   localparam int PC_W    = 64;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       flush;
   logic [FETCH_W-1:0]         fetch_valid;
   logic [FETCH_W*INSN_W-1:0]  fetch_insn;
   logic [FETCH_W*PC_W-1:0]    fetch_pc;
   logic                       fetch_ready;
   logic                       disp_valid;
   logic [INSN_W-1:0]          disp_insn;
   logic [PC_W-1:0]            disp_pc;
   logic                       disp_ready;
   logic [3:0]                 count;
   logic                       halted;

   int n_cmp = 0;
   int n_bad = 0;

   dispatch_queue #(
      .DEPTH(DEPTH), .FETCH_W(FETCH_W), .INSN_W(INSN_W), .PC_W(PC_W)
   ) dut (
      .in_clk            (clk),
      .in_rst_n          (rst_n),
      .in_flush          (flush),
      .in_fetch_valid    (fetch_valid),
      .in_fetch_insnbits (fetch_insn),
      .in_fetch_pc       (fetch_pc),
      .out_fetch_ready   (fetch_ready),
      .out_disp_valid    (disp_valid),
      .out_disp_insnbits (disp_insn),
      .out_disp_pc       (disp_pc),
      .in_disp_ready     (disp_ready),
      .out_count         (count),
      .out_halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [31:0] i0, input logic [31:0] i1);
      fetch_valid = v;
      fetch_pc    = {pc1, pc0};
      fetch_insn  = {i1, i0};
   endtask

   localparam logic [31:0] NOP = 32'hD503_201F;
   localparam logic [31:0] HLT = 32'hD440_0000;

   logic [63:0] drain_exp [7];

   initial begin
      rst_n = 1'b0; flush = 1'b0; disp_ready = 1'b0;
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(disp_valid), 64'd0);
      chk("rst_halted", 64'(halted), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", 64'(fetch_ready), 64'd1);

      // Fill: two per cycle, no dispatch
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 64'h1000 + 64'(8*k), 64'h1004 + 64'(8*k), 32'h1000_0000 + 32'(2*k), 32'h1000_0001 + 32'(2*k));
         tick();
         chk($sformatf("fill_count%0d", k), 64'(count), 64'(2*(k+1)));
         chk($sformatf("fill_ready%0d", k), 64'(fetch_ready), (k == 3) ? 64'd0 : 64'd1);
      end
      drive(2'b11, 64'hDEAD, 64'hBEEF, NOP, NOP);
      tick();
      chk("full_ignore_count", 64'(count), 64'd8);
      chk("full_head_pc", disp_pc, 64'h1000);
      chk("full_head_insn", 64'(disp_insn), 64'h1000_0000);

      // Flush while full with concurrent fetch and dispatch
      flush = 1'b1; disp_ready = 1'b1;
      #1;
      chk("flush_ready_comb", 64'(fetch_ready), 64'd0);
      tick();
      flush = 1'b0; disp_ready = 1'b0;
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      #1;
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(disp_valid), 64'd0);
      chk("flush_ready", 64'(fetch_ready), 64'd1);

      // Order
      drive(2'b11, 64'h100, 64'h104, 32'hA000_0100, 32'hA000_0104);
      tick();
      chk("ord_first_pc", disp_pc, 64'h100);
      chk("ord_first_insn", 64'(disp_insn), 64'hA000_0100);
      drive(2'b11, 64'h108, 64'h10C, 32'hA000_0108, 32'hA000_010C);
      tick();
      chk("ord_count", 64'(count), 64'd4);
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      disp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ord_pc%0d", k), disp_pc, 64'h100 + 64'(4*k));
         chk($sformatf("ord_insn%0d", k), 64'(disp_insn), 64'hA000_0100 + 64'(4*k));
         tick();
      end
      chk("ord_empty_valid", 64'(disp_valid), 64'd0);
      disp_ready = 1'b0;

      // Lane masking
      drive(2'b10, 64'h1F0, 64'h1F4, NOP, NOP);
      tick();
      chk("mask10_count", 64'(count), 64'd0);
      drive(2'b01, 64'h200, 64'h204, 32'hB000_0200, 32'hB000_0204);
      tick();
      chk("mask01_count", 64'(count), 64'd1);
      chk("mask01_pc", disp_pc, 64'h200);
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      disp_ready = 1'b1;
      tick();
      chk("mask01_drain", 64'(count), 64'd0);
      disp_ready = 1'b0;

      // Wrap: reach 7 entries with head at 5
      for (int k = 0; k < 3; k++) begin
         drive(2'b11, 64'h300 + 64'(8*k), 64'h304 + 64'(8*k), NOP, NOP);
         tick();
         chk($sformatf("wrap_fill%0d", k), 64'(count), 64'(2*(k+1)));
      end
      drive(2'b01, 64'h318, 64'h31C, NOP, NOP);
      tick();
      chk("wrap_count7", 64'(count), 64'd7);
      chk("wrap_ready7", 64'(fetch_ready), 64'd0);
      drive(2'b11, 64'h900, 64'h904, NOP, NOP);
      tick();
      chk("wrap_ignore7", 64'(count), 64'd7);
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      disp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("wrap_deq_pc%0d", k), disp_pc, 64'h300 + 64'(4*k));
         tick();
      end
      chk("wrap_after_deq", 64'(count), 64'd2);
      disp_ready = 1'b0;
      drive(2'b11, 64'h320, 64'h324, NOP, NOP);
      tick();
      chk("wrap_enq_a", 64'(count), 64'd4);
      drive(2'b11, 64'h328, 64'h32C, NOP, NOP);
      tick();
      chk("wrap_enq_b", 64'(count), 64'd6);
      // Simultaneous enqueue of two and dequeue of one
      drive(2'b11, 64'h330, 64'h334, NOP, NOP);
      disp_ready = 1'b1;
      chk("wrap_simul_head", disp_pc, 64'h314);
      tick();
      chk("wrap_simul_count", 64'(count), 64'd7);
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      drain_exp = '{64'h318, 64'h320, 64'h324, 64'h328, 64'h32C, 64'h330, 64'h334};
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("wrap_drain_pc%0d", k), disp_pc, drain_exp[k]);
         tick();
      end
      chk("wrap_drained", 64'(disp_valid), 64'd0);
      disp_ready = 1'b0;

      // HLT in lane 0 drops lane 1
      drive(2'b11, 64'h400, 64'h404, HLT, NOP);
      tick();
      chk("hlt0_count", 64'(count), 64'd1);
      chk("hlt0_halted", 64'(halted), 64'd1);
      chk("hlt0_ready", 64'(fetch_ready), 64'd0);
      chk("hlt0_insn", 64'(disp_insn), 64'(HLT));
      drive(2'b11, 64'h408, 64'h40C, NOP, NOP);
      tick();
      chk("hlt0_hold", 64'(count), 64'd1);
      chk("hlt0_ready_hold", 64'(fetch_ready), 64'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("hlt0_flush_halted", 64'(halted), 64'd0);
      chk("hlt0_flush_ready", 64'(fetch_ready), 64'd1);

      // HLT variant (imm bits set) in lane 1
      drive(2'b11, 64'h500, 64'h504, NOP, 32'hD45F_FFE0);
      tick();
      chk("hlt1_count", 64'(count), 64'd2);
      chk("hlt1_halted", 64'(halted), 64'd1);
      flush = 1'b1;
      drive(2'b00, 64'h0, 64'h0, NOP, NOP);
      tick();
      flush = 1'b0;

      // Asynchronous reset while full with a fetch group pending
      for (int k = 0; k < 4; k++) begin
         drive(2'b11, 64'h600 + 64'(8*k), 64'h604 + 64'(8*k), NOP, NOP);
         tick();
      end
      chk("ar_full", 64'(count), 64'd8);
      drive(2'b11, 64'h700, 64'h704, 32'hC000_0700, NOP);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_count", 64'(count), 64'd0);
      chk("ar_valid", 64'(disp_valid), 64'd0);
      chk("ar_ready", 64'(fetch_ready), 64'd1);
      #1;
      rst_n = 1'b1;
      tick();
      chk("ar_first_edge", 64'(count), 64'd2);
      chk("ar_first_pc", disp_pc, 64'h700);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
